// File: rtl/audio_out_mixer.sv
// ---------------------------------------------------------------------------
// audio_out_mixer
//
// Purpose:
//    Last stage of the game music synthesiser. It captures four signed voice
//    samples together with their gains and an optional stereo line
//    passthrough. It mixes them, saturates to 32 bits and applies a slowly
//    ramping master level. It then hands one stereo sample per handshake to
//    the Audio_Controller output FIFO.
//
//    The FSM runs IDLE -> ACC -> SAT -> WRITE:
//       IDLE  : wait for FIFO room, then snapshot every input of the sample.
//       ACC   : gain-scale each voice, sum them, add the passthrough.
//       SAT   : clamp to 32 bits, apply the captured master level, track clips.
//       WRITE : present the sample and wait for the FIFO to accept it.
//
// Parameters:
//    FADE_DIV    completed writes per master-level step (1..255)
//    CLIP_CNT_W  width of the saturating clip counter
//
// Ports:
//    CLOCK_50                   system clock
//    reset                      synchronous, active-high reset
//    voice0_sample..voice3      signed 32-bit voice samples
//    voice_gain                 four unsigned 4-bit gains, voice n at [4n+3:4n], 8 = unity
//    pass_left / pass_right     signed 32-bit passthrough samples
//    pass_en                    include passthrough in the mix
//    mute                       1 fades master to 0, 0 fades master to 16
//    audio_out_allowed          output FIFO has room
//    left/right_channel_audio_out  registered signed output samples
//    write_audio_out            write strobe to the Audio_Controller
//    master_level               current master level, 0..16
//    clip_flag                  sticky: some sample has clipped
//    clip_count                 saturating count of clipped samples
//    busy                       FSM is not in IDLE
// ---------------------------------------------------------------------------
module audio_out_mixer #(
    parameter int unsigned FADE_DIV   = 48,
    parameter int unsigned CLIP_CNT_W = 16
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic signed [31:0]           voice0_sample,
    input  logic signed [31:0]           voice1_sample,
    input  logic signed [31:0]           voice2_sample,
    input  logic signed [31:0]           voice3_sample,
    input  logic        [15:0]           voice_gain,
    input  logic signed [31:0]           pass_left,
    input  logic signed [31:0]           pass_right,
    input  logic                         pass_en,
    input  logic                         mute,
    input  logic                         audio_out_allowed,
    output logic signed [31:0]           left_channel_audio_out,
    output logic signed [31:0]           right_channel_audio_out,
    output logic                         write_audio_out,
    output logic        [4:0]            master_level,
    output logic                         clip_flag,
    output logic        [CLIP_CNT_W-1:0] clip_count,
    output logic                         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        SAT   = 2'd2,
        WRITE = 2'd3
    } state_e;

    localparam logic [7:0]            DIV_LAST  = 8'(FADE_DIV - 1);
    localparam logic [4:0]            LEVEL_MAX = 5'd16;
    localparam logic [CLIP_CNT_W-1:0] CLIP_MAX  = {CLIP_CNT_W{1'b1}};
    localparam logic [CLIP_CNT_W-1:0] CLIP_ONE  = {{(CLIP_CNT_W-1){1'b0}}, 1'b1};

    state_e                  state_q;

    // Per-sample snapshot taken in IDLE. Everything downstream works only
    // from these, so input changes after capture never leak into the sample.
    logic signed [31:0]      voice0_q;
    logic signed [31:0]      voice1_q;
    logic signed [31:0]      voice2_q;
    logic signed [31:0]      voice3_q;
    logic        [15:0]      gain_q;
    logic signed [31:0]      passL_q;
    logic signed [31:0]      passR_q;
    logic        [4:0]       masterCap_q;

    logic signed [39:0]      accL_q;
    logic signed [39:0]      accR_q;
    logic signed [39:0]      accL_d;
    logic signed [39:0]      accR_d;

    logic signed [31:0]      leftOut_q;
    logic signed [31:0]      rightOut_q;
    logic signed [31:0]      leftOut_d;
    logic signed [31:0]      rightOut_d;
    logic                    clipL_d;
    logic                    clipR_d;

    logic        [4:0]       master_q;
    logic        [4:0]       master_d;
    logic        [7:0]       fadeDiv_q;
    logic        [7:0]       fadeDiv_d;

    logic                    clipFlag_q;
    logic [CLIP_CNT_W-1:0]   clipCount_q;
    logic [CLIP_CNT_W-1:0]   clipCount_d;

    // Gain-scale one voice: (voice * gain) >>> 3 in 37 bits, floor shift,
    // sign-extended to the 40-bit accumulator width.
    function automatic logic signed [39:0] scaleVoice(input logic signed [31:0] v,
                                                      input logic        [3:0]  g);
        logic signed [36:0] prod;
        prod = $signed({{5{v[31]}}, v}) * $signed({33'd0, g});
        prod = prod >>> 3;
        return {{3{prod[36]}}, prod};
    endfunction

    // A 40-bit value fits in 32 signed bits only when bits [39:31] agree.
    function automatic logic isClip(input logic signed [39:0] x);
        return ~((&x[39:31]) | ~(|x[39:31]));
    endfunction

    function automatic logic signed [31:0] clamp32(input logic signed [39:0] x);
        logic signed [31:0] res;
        if (!isClip(x)) begin
            res = x[31:0];
        end else if (x[39]) begin
            res = 32'sh8000_0000;
        end else begin
            res = 32'sh7FFF_FFFF;
        end
        return res;
    endfunction

    // Master scaling: (clamped * level) >>> 4. With level <= 16, the result
    // magnitude never exceeds the clamped input, so truncation to 32 bits
    // is exact.
    function automatic logic signed [31:0] applyMaster(input logic signed [31:0] c,
                                                       input logic        [4:0]  m);
        logic signed [37:0] prod;
        prod = $signed({{6{c[31]}}, c}) * $signed({33'd0, m});
        return 32'(prod >>> 4);
    endfunction

    // Mix datapath used in ACC: four scaled voices plus the captured
    // passthrough (already forced to zero at capture when pass_en was low).
    always_comb begin
        logic signed [39:0] mix;
        mix = scaleVoice(voice0_q, gain_q[3:0])
            + scaleVoice(voice1_q, gain_q[7:4])
            + scaleVoice(voice2_q, gain_q[11:8])
            + scaleVoice(voice3_q, gain_q[15:12]);
        accL_d = mix + {{8{passL_q[31]}}, passL_q};
        accR_d = mix + {{8{passR_q[31]}}, passR_q};
    end

    // Saturation and master scaling used in SAT. A sample counts as one clip
    // no matter whether one or both channels clamped.
    always_comb begin
        clipL_d    = isClip(accL_q);
        clipR_d    = isClip(accR_q);
        leftOut_d  = applyMaster(clamp32(accL_q), masterCap_q);
        rightOut_d = applyMaster(clamp32(accR_q), masterCap_q);
        clipCount_d = clipCount_q;
        if ((clipL_d || clipR_d) && (clipCount_q != CLIP_MAX)) begin
            clipCount_d = clipCount_q + CLIP_ONE;
        end
    end

    // Fade bookkeeping for the next completed write. The divider is never
    // cleared by a mute change, so the ramp cadence stays steady even when
    // the target flips part-way through a step.
    always_comb begin
        fadeDiv_d = fadeDiv_q + 8'd1;
        master_d  = master_q;
        if (fadeDiv_q >= DIV_LAST) begin
            fadeDiv_d = 8'd0;
            if (mute && (master_q != 5'd0)) begin
                master_d = master_q - 5'd1;
            end else if (!mute && (master_q != LEVEL_MAX)) begin
                master_d = master_q + 5'd1;
            end
        end
    end

    // Main sequencer. Reset drops any sample in flight and returns every
    // visible register to zero, which also restarts the power-up fade-in.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            voice0_q    <= '0;
            voice1_q    <= '0;
            voice2_q    <= '0;
            voice3_q    <= '0;
            gain_q      <= '0;
            passL_q     <= '0;
            passR_q     <= '0;
            masterCap_q <= '0;
            accL_q      <= '0;
            accR_q      <= '0;
            leftOut_q   <= '0;
            rightOut_q  <= '0;
            master_q    <= '0;
            fadeDiv_q   <= '0;
            clipFlag_q  <= 1'b0;
            clipCount_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (audio_out_allowed) begin
                        voice0_q    <= voice0_sample;
                        voice1_q    <= voice1_sample;
                        voice2_q    <= voice2_sample;
                        voice3_q    <= voice3_sample;
                        gain_q      <= voice_gain;
                        passL_q     <= pass_en ? pass_left  : 32'sd0;
                        passR_q     <= pass_en ? pass_right : 32'sd0;
                        masterCap_q <= master_q;
                        state_q     <= ACC;
                    end
                end
                ACC: begin
                    accL_q  <= accL_d;
                    accR_q  <= accR_d;
                    state_q <= SAT;
                end
                SAT: begin
                    leftOut_q   <= leftOut_d;
                    rightOut_q  <= rightOut_d;
                    clipCount_q <= clipCount_d;
                    if (clipL_d || clipR_d) begin
                        clipFlag_q <= 1'b1;
                    end
                    state_q <= WRITE;
                end
                WRITE: begin
                    // The strobe is combinational on audio_out_allowed, so
                    // leaving WRITE here coincides with exactly one accepted
                    // write. While the FIFO is full, the outputs simply hold.
                    if (audio_out_allowed) begin
                        fadeDiv_q <= fadeDiv_d;
                        master_q  <= master_d;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign write_audio_out         = (state_q == WRITE) && audio_out_allowed;
    assign busy                    = (state_q != IDLE);
    assign left_channel_audio_out  = leftOut_q;
    assign right_channel_audio_out = rightOut_q;
    assign master_level            = master_q;
    assign clip_flag               = clipFlag_q;
    assign clip_count              = clipCount_q;

endmodule

// File: tb/tb_audio_out_mixer.sv
// ---------------------------------------------------------------------------
// tb_audio_out_mixer
//
// Directed bench for audio_out_mixer with FADE_DIV=2 and a 4-bit clip
// counter, so the fade and counter saturation are reached quickly. Steady-
// state mixing cases at full master level come from a vector table. Power-up
// ramp, back-pressure, fade and mid-pipeline reset are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_audio_out_mixer;

    localparam int TB_FADE_DIV = 2;
    localparam int TB_CLIP_W   = 4;
    localparam int NUM_VECS    = 14;

    logic                        CLOCK_50;
    logic                        reset;
    logic signed [31:0]          voice0_sample;
    logic signed [31:0]          voice1_sample;
    logic signed [31:0]          voice2_sample;
    logic signed [31:0]          voice3_sample;
    logic        [15:0]          voice_gain;
    logic signed [31:0]          pass_left;
    logic signed [31:0]          pass_right;
    logic                        pass_en;
    logic                        mute;
    logic                        audio_out_allowed;
    logic signed [31:0]          left_channel_audio_out;
    logic signed [31:0]          right_channel_audio_out;
    logic                        write_audio_out;
    logic        [4:0]           master_level;
    logic                        clip_flag;
    logic        [TB_CLIP_W-1:0] clip_count;
    logic                        busy;

    int errors      = 0;
    int checks      = 0;
    int strobeCount = 0;
    int writesDone  = 0;
    int masterModel = 0;
    int divModel    = 0;
    int clipModel   = 0;
    bit flagModel   = 0;

    typedef struct {
        logic signed [31:0] v0;
        logic signed [31:0] v1;
        logic signed [31:0] v2;
        logic signed [31:0] v3;
        logic        [15:0] gain;
        logic               passEn;
        logic signed [31:0] pl;
        logic signed [31:0] pr;
        logic signed [31:0] expL;
        logic signed [31:0] expR;
        logic               expClip;
    } vec_t;

    vec_t vecs [NUM_VECS];

    audio_out_mixer #(
        .FADE_DIV   (TB_FADE_DIV),
        .CLIP_CNT_W (TB_CLIP_W)
    ) dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .voice0_sample           (voice0_sample),
        .voice1_sample           (voice1_sample),
        .voice2_sample           (voice2_sample),
        .voice3_sample           (voice3_sample),
        .voice_gain              (voice_gain),
        .pass_left               (pass_left),
        .pass_right              (pass_right),
        .pass_en                 (pass_en),
        .mute                    (mute),
        .audio_out_allowed       (audio_out_allowed),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .write_audio_out         (write_audio_out),
        .master_level            (master_level),
        .clip_flag               (clip_flag),
        .clip_count              (clip_count),
        .busy                    (busy)
    );

    // 50 MHz-style clock, 10 time-unit period.
    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // Independent strobe counter, sampled on the inactive edge.
    always @(negedge CLOCK_50) begin
        if (write_audio_out === 1'b1) begin
            strobeCount++;
        end
    end

    // Safety net so a stuck design can never hang the run.
    initial begin
        #400000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        voice0_sample     = v.v0;
        voice1_sample     = v.v1;
        voice2_sample     = v.v2;
        voice3_sample     = v.v3;
        voice_gain        = v.gain;
        pass_en           = v.passEn;
        pass_left         = v.pl;
        pass_right        = v.pr;
        audio_out_allowed = 1'b1;
    endtask

    // Wait (bounded) for the next strobe, return the sample shown with it and
    // the number of cycles waited, then let the write complete and check the
    // master level against the fade model.
    task automatic waitWrite(output logic signed [31:0] l, output logic signed [31:0] r,
                             output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        l   = '0;
        r   = '0;
        while (!got && cyc < 40) begin
            @(negedge CLOCK_50);
            cyc++;
            if (write_audio_out === 1'b1) begin
                got = 1'b1;
                l   = left_channel_audio_out;
                r   = right_channel_audio_out;
            end
        end
        if (!got) begin
            checkOutput("writeTimeout", 64'd0, 64'd1);
        end else begin
            @(posedge CLOCK_50);
            #1;
            writesDone++;
            divModel++;
            if (divModel == TB_FADE_DIV) begin
                divModel = 0;
                if (mute && masterModel > 0) begin
                    masterModel--;
                end else if (!mute && masterModel < 16) begin
                    masterModel++;
                end
            end
            checkOutput("masterLevel", master_level, masterModel);
        end
    endtask

    task automatic resetModels();
        masterModel = 0;
        divModel    = 0;
        clipModel   = 0;
        flagModel   = 1'b0;
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, ".strobe"}, write_audio_out, 0);
        checkOutput({tag, ".left"},   left_channel_audio_out, 0);
        checkOutput({tag, ".right"},  right_channel_audio_out, 0);
        checkOutput({tag, ".master"}, master_level, 0);
        checkOutput({tag, ".flag"},   clip_flag, 0);
        checkOutput({tag, ".count"},  clip_count, 0);
        checkOutput({tag, ".busy"},   busy, 0);
    endtask

    initial begin
        logic signed [31:0] l;
        logic signed [31:0] r;
        int cyc;

        // v0, v1, v2, v3, gain, passEn, pl, pr, expL, expR, expClip (master = 16)
        vecs[0]  = '{32'sd0, -32'sd800, 32'sd0, 32'sd0, 16'h0040, 1'b0, 32'sd0, 32'sd0,
                     -32'sd400, -32'sd400, 1'b0};
        vecs[1]  = '{32'sd0, 32'sd0, 32'sd8000, 32'sd0, 16'h0F00, 1'b0, 32'sd0, 32'sd0,
                     32'sd15000, 32'sd15000, 1'b0};
        vecs[2]  = '{32'sd0, -32'sd800, 32'sd8000, 32'sd0, 16'h0F40, 1'b0, 32'sd0, 32'sd0,
                     32'sd14600, 32'sd14600, 1'b0};
        vecs[3]  = '{32'sd0, -32'sd800, 32'sd8000, 32'sd0, 16'h0F40, 1'b1, 32'sd5, -32'sd5,
                     32'sd14605, 32'sd14595, 1'b0};
        vecs[4]  = '{-32'sd3, 32'sd0, 32'sd0, 32'sd0, 16'h0001, 1'b0, 32'sd0, 32'sd0,
                     -32'sd1, -32'sd1, 1'b0};
        vecs[5]  = '{32'sd7, 32'sd0, 32'sd0, 32'sd0, 16'h0001, 1'b0, 32'sd0, 32'sd0,
                     32'sd0, 32'sd0, 1'b0};
        vecs[6]  = '{32'sd1000, 32'sd0, 32'sd0, 32'sd0, 16'h0008, 1'b0, 32'sd100, -32'sd100,
                     32'sd1000, 32'sd1000, 1'b0};
        vecs[7]  = '{32'sd0, 32'sd0, 32'sd0, 32'sd1000, 16'h8000, 1'b0, 32'sd0, 32'sd0,
                     32'sd1000, 32'sd1000, 1'b0};
        vecs[8]  = '{32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 16'hFFFF,
                     1'b0, 32'sd0, 32'sd0, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 1'b1};
        vecs[9]  = '{32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 16'hFFFF,
                     1'b0, 32'sd0, 32'sd0, 32'sh8000_0000, 32'sh8000_0000, 1'b1};
        vecs[10] = '{32'sh7FFF_FFFF, 32'sd0, 32'sd0, 32'sd0, 16'h0008, 1'b1, 32'sd1, 32'sd0,
                     32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 1'b1};
        vecs[11] = '{32'sh7FFF_FFFF, 32'sd0, 32'sd0, 32'sd0, 16'h0008, 1'b0, 32'sd0, 32'sd0,
                     32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 1'b0};
        vecs[12] = '{32'sh8000_0000, 32'sd0, 32'sd0, 32'sd0, 16'h0008, 1'b0, 32'sd0, 32'sd0,
                     32'sh8000_0000, 32'sh8000_0000, 1'b0};
        vecs[13] = '{32'sh8000_0000, 32'sd0, 32'sd0, 32'sd0, 16'h0008, 1'b1, 32'sd0, -32'sd1,
                     32'sh8000_0000, 32'sh8000_0000, 1'b1};

        // ---- reset state ----
        reset             = 1'b1;
        voice0_sample     = '0;
        voice1_sample     = '0;
        voice2_sample     = '0;
        voice3_sample     = '0;
        voice_gain        = '0;
        pass_left         = '0;
        pass_right        = '0;
        pass_en           = 1'b0;
        mute              = 1'b0;
        audio_out_allowed = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        checkCleared("reset");
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        resetModels();

        // ---- power-up ramp with unity gain on voice 0 ----
        applyStimulus(vecs[6]);
        for (int i = 0; i < 32; i++) begin
            waitWrite(l, r, cyc);
        end
        checkOutput("rampLevel", master_level, 16);
        for (int i = 0; i < 2; i++) begin
            waitWrite(l, r, cyc);
            checkOutput("unityLeft", l, 32'sd1000);
            checkOutput("unityRight", r, 32'sd1000);
            checkOutput("cadence", cyc, 4);
        end

        // ---- table of mixing / saturation cases at master 16 ----
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            waitWrite(l, r, cyc);
            if (vecs[i].expClip) begin
                flagModel = 1'b1;
                if (clipModel < 15) clipModel++;
            end
            checkOutput($sformatf("vec%0d.left", i), l, vecs[i].expL);
            checkOutput($sformatf("vec%0d.right", i), r, vecs[i].expR);
            checkOutput($sformatf("vec%0d.clipCount", i), clip_count, clipModel);
            checkOutput($sformatf("vec%0d.clipFlag", i), clip_flag, flagModel);
        end

        // ---- clip counter saturates at all-ones ----
        applyStimulus(vecs[8]);
        for (int i = 0; i < 14; i++) begin
            waitWrite(l, r, cyc);
        end
        checkOutput("clipSat", clip_count, 15);
        waitWrite(l, r, cyc);
        checkOutput("clipSatHold", clip_count, 15);
        checkOutput("clipSatFlag", clip_flag, 1);

        // ---- back-pressure: FIFO full for 10 cycles while in WRITE ----
        applyStimulus(vecs[6]);
        @(posedge CLOCK_50);
        #1;
        checkOutput("bpCaptured", busy, 1);
        audio_out_allowed = 1'b0;
        voice0_sample     = 32'sd5000;
        voice_gain        = 16'h000F;
        @(posedge CLOCK_50);
        #1;
        @(posedge CLOCK_50);
        #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            checkOutput("bpStrobe", write_audio_out, 0);
            checkOutput("bpLeft", left_channel_audio_out, 32'sd1000);
            checkOutput("bpRight", right_channel_audio_out, 32'sd1000);
            checkOutput("bpBusy", busy, 1);
            @(posedge CLOCK_50);
            #1;
        end
        audio_out_allowed = 1'b1;
        waitWrite(l, r, cyc);
        audio_out_allowed = 1'b0;
        checkOutput("bpReleaseLeft", l, 32'sd1000);
        checkOutput("bpReleaseCyc", cyc, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            checkOutput("bpSingleStrobe", write_audio_out, 0);
        end
        checkOutput("writeCount", strobeCount, writesDone);

        // ---- fade: mute down to 0, then back up to 16 ----
        applyStimulus(vecs[6]);
        mute = 1'b1;
        for (int i = 0; i < 32; i++) begin
            waitWrite(l, r, cyc);
        end
        checkOutput("muteLevel", master_level, 0);
        waitWrite(l, r, cyc);
        checkOutput("mutedLeft", l, 0);
        checkOutput("mutedRight", r, 0);
        mute = 1'b0;
        for (int i = 0; i < 40 && masterModel != 8; i++) begin
            waitWrite(l, r, cyc);
        end
        checkOutput("midLevel", master_level, 8);
        waitWrite(l, r, cyc);
        checkOutput("halfLeft", l, 32'sd500);
        checkOutput("halfRight", r, 32'sd500);
        for (int i = 0; i < 32; i++) begin
            waitWrite(l, r, cyc);
        end
        checkOutput("unmuteLevel", master_level, 16);
        waitWrite(l, r, cyc);
        checkOutput("unmuteLeft", l, 32'sd1000);

        // ---- reset while in ACC ----
        applyStimulus(vecs[8]);
        @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        @(negedge CLOCK_50);
        checkCleared("rstAcc");
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        resetModels();

        // ---- rebuild some state, then reset while in SAT ----
        for (int i = 0; i < 8; i++) begin
            waitWrite(l, r, cyc);
            if (clipModel < 15) clipModel++;
        end
        checkOutput("preSatCount", clip_count, 8);
        checkOutput("preSatLevel", master_level, 4);
        @(posedge CLOCK_50);
        #1;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        @(negedge CLOCK_50);
        checkCleared("rstSat");
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        resetModels();

        // ---- operation resumes after reset at master 0 ----
        applyStimulus(vecs[6]);
        waitWrite(l, r, cyc);
        checkOutput("postRstLeft", l, 0);
        checkOutput("postRstCyc", cyc, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_out_mixer.md
# audio_out_mixer

Downstream stage of the game music synthesiser. It takes four signed voice samples (melody, kick, snare, hi-hat), applies a per-voice gain to each, and sums them. An optional line passthrough is added per channel, and the result is saturated and scaled by a click-free master fade. It then writes one stereo sample per handshake into the Audio_Controller output FIFO through the `audio_out_allowed` / `write_audio_out` interface.

## Interface
- `FADE_DIV`, 48: completed sample writes per master-level step (1..255).
- `CLIP_CNT_W`, 16: width of the clip counter.
- `CLOCK_50`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `voice0_sample`..`voice3_sample`  in  32 each  signed two's-complement voice samples.
- `voice_gain`  in  16  four unsigned 4-bit gains; voice n uses bits [4n+3:4n]. Gain 8 = unity.
- `pass_left`, `pass_right`  in  32 each  signed passthrough samples.
- `pass_en`  in  1  adds passthrough to the mix when 1.
- `mute`  in  1  1 = fade master level to 0; 0 = fade master level to 16.
- `audio_out_allowed`  in  1  Audio_Controller output FIFO has room.
- `left_channel_audio_out`, `right_channel_audio_out`  out  32 each  registered signed output samples.
- `write_audio_out`  out  1  write strobe to Audio_Controller.
- `master_level`  out  5  current master level, 0..16.
- `clip_flag`  out  1  sticky flag: a clip has occurred.
- `clip_count`  out  CLIP_CNT_W  saturating count of clipped samples.
- `busy`  out  1  1 when the state machine is not in IDLE.

## Operation
- The FSM has four states: IDLE, ACC, SAT, WRITE. Reset enters IDLE.
- IDLE: when `audio_out_allowed`=1, register all four voices, all gains, `pass_left`/`pass_right` (or 0 if `pass_en`=0), and `master_level`, then go to ACC. Otherwise stay in IDLE.
- ACC:
  - Compute p_n = (voice_n × zero-extended gain_n) >>> 3, as 37-bit signed with an arithmetic (floor) shift.
  - Compute mix = Σp_n, sign-extended to 40 bits.
  - Compute L = mix + pass_left and R = mix + pass_right, both 40-bit.
  - Register L and R, then go to SAT.
- SAT:
  - Clamp each of L and R to [−2^31, 2^31−1].
  - Load each output with (clamped × captured master) >>> 4, floor. There is no overflow because master ≤ 16.
  - If either channel was clamped, set `clip_flag` and increment `clip_count` by 1 per sample (not per channel), saturating at all-ones.
  - Go to WRITE.
- WRITE: `write_audio_out` = (state==WRITE) & `audio_out_allowed`, combinational.
  - If `audio_out_allowed`=1, go to IDLE and count one completed write.
  - If `audio_out_allowed`=0, hold the outputs, keep the strobe low and stay in WRITE. There are no duplicate or dropped writes.
- Fade:
  - A divider counts completed writes from 0 to FADE_DIV−1.
  - On wrap, `master_level` moves by 1 toward its target: 0 if `mute`=1, 16 if `mute`=0. It holds when it reaches the target.
  - A `mute` toggle does not reset the divider.
- Master is captured in IDLE, so a level change never takes effect mid-sample. Gain or voice changes after capture also do not affect the sample in flight.

## Timing
- Reset values: outputs 0, `write_audio_out` 0, `master_level` 0, `clip_flag` 0, `clip_count` 0, divider 0, `busy` 0.
- At power-up, the level ramps 0→16 over 16×FADE_DIV writes.
- Reset asserted in any state: at the next edge the FSM is in IDLE and all state above returns to its reset values. Any in-flight sample is discarded; the strobe is low in the cycle after that edge.
- Latency: capture edge E0 (IDLE→ACC), E1 (ACC→SAT), E2 (SAT→WRITE, outputs valid). The strobe is high in the cycle after E2.
- Minimum sample period is 4 cycles. The Audio_Controller FIFO back-pressure through `audio_out_allowed` paces the actual rate.
- `audio_out_allowed` dropping between capture and WRITE causes no stall before WRITE; the wait happens only in WRITE.
- A fade step and a clip can occur on the same sample; both are updated.
- The clip counter at all-ones stays at all-ones.

## Test plan
- Unity gain:
  - Stimulus: after reset, `audio_out_allowed`=1, `mute`=0, FADE_DIV=2, `voice0_sample`=1000, gain0=8, other gains 0, `pass_en`=0. Run 32 writes.
  - Required: `master_level`=16; each subsequent write outputs 1000 on both channels.
  - Also check the write cadence: every 4 cycles.
- Gain scaling with master=16:
  - voice1=−800, gain1=4 → −400.
  - voice2=8000, gain2=15 → 15000.
  - Both together → 14600.
  - `pass_en`=1, `pass_left`=5, `pass_right`=−5 → 14605 / 14595.
- Saturation, with master=16:
  - All voices 0x7FFFFFFF, gains 15 → both outputs 0x7FFFFFFF, `clip_flag`=1, `clip_count` +1 per write.
  - All voices 0x80000000 → both outputs 0x80000000.
- Back-pressure: drop `audio_out_allowed` for 10 cycles while in WRITE.
  - Required: strobe low and outputs stable for those 10 cycles.
  - Required: exactly one strobe cycle after `audio_out_allowed` returns; total write count matches the number of captures.
- Fade, with FADE_DIV=2 and master=16:
  - Assert `mute`: level decrements by 1 every 2 writes and reaches 0 after 32 writes; outputs are then 0.
  - Deassert `mute`: level ramps back to 16.
  - At master=8 with voice 1000 at unity → output 500.
- Reset mid-pipeline: assert `reset` in ACC and again in SAT.
  - Required: no strobe in the cycle after the reset edge.
  - Required: all outputs, `master_level`, `clip_flag` and `clip_count` return to 0.
